// File: rtl/raycast_column_scheduler_if.sv
// Raytracer job bus plus column-draw result stream for the column scheduler.
// master = scheduler side, slave = raytracer / draw-stage side.
interface raycast_column_scheduler_if #(
  parameter int unsigned COL_W = 8
);
  logic             rt_start;
  logic [13:0]      rt_x;
  logic [12:0]      rt_y;
  logic [7:0]       rt_angle;
  logic             rt_done;
  logic [5:0]       rt_result_x;
  logic [4:0]       rt_result_y;
  logic             col_valid;
  logic             col_ready;
  logic [COL_W-1:0] col_index;
  logic [5:0]       col_hit_x;
  logic [4:0]       col_hit_y;
  logic             col_miss;

  modport master (
    output rt_start, rt_x, rt_y, rt_angle,
    input  rt_done, rt_result_x, rt_result_y,
    output col_valid, col_index, col_hit_x, col_hit_y, col_miss,
    input  col_ready
  );

  modport slave (
    input  rt_start, rt_x, rt_y, rt_angle,
    output rt_done, rt_result_x, rt_result_y,
    input  col_valid, col_index, col_hit_x, col_hit_y, col_miss,
    output col_ready
  );
endinterface

// File: rtl/raycast_column_scheduler.sv
// Frame sequencer: sweeps NUM_COLS columns, launching one raytracer job per column and streaming
// each hit cell to the draw stage. A watchdog turns runaway rays into misses.
module raycast_column_scheduler #(
  parameter int unsigned NUM_COLS   = 160,
  parameter int unsigned COL_W      = 8,
  parameter int unsigned FOV        = 43,
  parameter int unsigned MAX_CYCLES = 1024
) (
  input  logic                              clock,
  input  logic                              resetn,
  input  logic                              frame_start,
  input  logic [13:0]                       player_x,
  input  logic [12:0]                       player_y,
  input  logic [7:0]                        player_angle,
  raycast_column_scheduler_if.master        bus,
  output logic                              busy,
  output logic                              frame_done
);

  localparam int unsigned       WdW       = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [15:0]       AngleStep = 16'((FOV << 8) / NUM_COLS);
  localparam logic [15:0]       HalfFov   = 16'(FOV << 7);
  localparam logic [COL_W-1:0]  LastCol   = COL_W'(NUM_COLS - 1);
  localparam logic [WdW-1:0]    WdLast    = WdW'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StLaunch, StWaitRt, StEmit, StDrain, StFrameEnd, StDrainEnd
  } state_e;

  state_e           state_q, state_d;
  logic [13:0]      pos_x_q, pos_x_d;
  logic [12:0]      pos_y_q, pos_y_d;
  logic [15:0]      acc_q, acc_d;
  logic [COL_W-1:0] col_idx_q, col_idx_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic [5:0]       hit_x_q, hit_x_d;
  logic [4:0]       hit_y_q, hit_y_d;
  logic             miss_q, miss_d;
  logic             drain_q, drain_d;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      acc_q     <= '0;
      col_idx_q <= '0;
      wd_q      <= '0;
      hit_x_q   <= '0;
      hit_y_q   <= '0;
      miss_q    <= 1'b0;
      drain_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      acc_q     <= acc_d;
      col_idx_q <= col_idx_d;
      wd_q      <= wd_d;
      hit_x_q   <= hit_x_d;
      hit_y_q   <= hit_y_d;
      miss_q    <= miss_d;
      drain_q   <= drain_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    acc_d     = acc_q;
    col_idx_d = col_idx_q;
    wd_d      = wd_q;
    hit_x_d   = hit_x_q;
    hit_y_d   = hit_y_q;
    miss_d    = miss_q;
    // A late completion from a timed-out job retires it whatever state we are in.
    drain_d   = bus.rt_done ? 1'b0 : drain_q;

    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          pos_x_d   = player_x;
          pos_y_d   = player_y;
          col_idx_d = '0;
          acc_d     = {player_angle, 8'h00} - HalfFov;
          state_d   = StLaunch;
        end
      end
      StLaunch: begin
        wd_d    = '0;
        state_d = StWaitRt;
      end
      StWaitRt: begin
        wd_d = wd_q + WdW'(1);
        if (bus.rt_done) begin
          hit_x_d = bus.rt_result_x;
          hit_y_d = bus.rt_result_y;
          miss_d  = 1'b0;
          state_d = StEmit;
        end else if (wd_q == WdLast) begin
          hit_x_d = '0;
          hit_y_d = '0;
          miss_d  = 1'b1;
          drain_d = 1'b1;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (bus.col_ready) begin
          if (col_idx_q == LastCol) begin
            state_d = StFrameEnd;
          end else begin
            col_idx_d = col_idx_q + COL_W'(1);
            acc_d     = acc_q + AngleStep;
            state_d   = drain_q ? StDrain : StLaunch;
          end
        end
      end
      StDrain: begin
        if (!drain_q) state_d = StLaunch;
      end
      StFrameEnd: begin
        state_d = drain_q ? StDrainEnd : StIdle;
      end
      StDrainEnd: begin
        if (!drain_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.rt_start  = (state_q == StLaunch);
  assign bus.rt_x      = pos_x_q;
  assign bus.rt_y      = pos_y_q;
  assign bus.rt_angle  = acc_q[15:8];
  assign bus.col_valid = (state_q == StEmit);
  assign bus.col_index = col_idx_q;
  assign bus.col_hit_x = hit_x_q;
  assign bus.col_hit_y = hit_y_q;
  assign bus.col_miss  = miss_q;
  assign busy          = (state_q != StIdle);
  assign frame_done    = (state_q == StFrameEnd);

endmodule

// File: tb/tb_raycast_column_scheduler.sv
// Scoreboard bench for raycast_column_scheduler: a raytracer model issues expected beats into a
// queue at each launch; an independent monitor pops and compares every accepted column.
module tb_raycast_column_scheduler;
  localparam int NUM_COLS   = 160;
  localparam int COL_W      = 8;
  localparam int FOV        = 43;
  localparam int MAX_CYCLES = 1024;
  localparam int STEP       = (FOV * 256) / NUM_COLS;

  typedef struct {
    int idx;
    int hx;
    int hy;
    int miss;
  } beat_t;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic        frame_start = 1'b0;
  logic [13:0] player_x = '0;
  logic [12:0] player_y = '0;
  logic [7:0]  player_angle = '0;
  logic        busy;
  logic        frame_done;

  raycast_column_scheduler_if #(.COL_W(COL_W)) bus ();

  raycast_column_scheduler #(
    .NUM_COLS  (NUM_COLS),
    .COL_W     (COL_W),
    .FOV       (FOV),
    .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .frame_start (frame_start),
    .player_x    (player_x),
    .player_y    (player_y),
    .player_angle(player_angle),
    .bus         (bus),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  beat_t exp_q[$];
  beat_t mon_e;
  int checks = 0;
  int errors = 0;
  int cycle = 0;

  // Reference model state
  int m_x, m_y, m_a;
  int rt_col = 0;
  bit outstanding = 0;
  bit pend_valid = 0;
  int pend_at, pend_rx, pend_ry;
  int start_cyc, done_cyc, accept_cyc;
  int wd_col = -1;
  int fixed_delay = 0;
  bit prev_miss = 0;
  bit fs_check = 0;
  int fs_cyc;
  bit b2b_check = 0;
  int last_fd_cyc = 0;
  int frame_cnt = 0;
  int beats = 0;
  int bp_col = -1;
  int bp_cnt = 0;
  bit rand_ready = 0;
  int exp_ang;

  // Monitor state
  bit prev_valid = 0;
  bit prev_fd = 0;
  bit stalled = 0;
  int sv_idx, sv_hx, sv_hy, sv_miss;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever #5 clock = ~clock;
  initial forever begin
    @(posedge clock);
    cycle++;
  end

  // Raytracer model: check launch, push expected beat, schedule the completion.
  initial forever begin
    @(negedge clock);
    if (resetn && bus.rt_start) begin
      chk("rt_start_while_busy", {30'd0, outstanding, bus.col_valid}, 0);
      exp_ang = ((((m_a * 256 - FOV * 128 + rt_col * STEP) % 65536) + 65536) % 65536) / 256;
      chk("rt_angle", bus.rt_angle, exp_ang);
      chk("rt_x", bus.rt_x, m_x);
      chk("rt_y", bus.rt_y, m_y);
      if (m_a == 0) begin
        if (rt_col == 0)   chk("angle_col0", bus.rt_angle, 234);
        if (rt_col == 1)   chk("angle_col1", bus.rt_angle, 234);
        if (rt_col == 80)  chk("angle_col80", bus.rt_angle, 255);
        if (rt_col == 159) chk("angle_col159", bus.rt_angle, 20);
      end
      if (rt_col == 0 && fs_check) begin
        chk("start_latency", cycle, fs_cyc + 1);
        fs_check = 0;
      end else if (rt_col == 0 && b2b_check) begin
        chk("b2b_latency", cycle, last_fd_cyc + 2);
        b2b_check = 0;
      end else if (rt_col != 0 && !prev_miss) begin
        chk("launch_after_accept", cycle, accept_cyc + 1);
      end
      outstanding = 1;
      start_cyc = cycle;
      pend_rx = $urandom_range(0, 63);
      pend_ry = $urandom_range(0, 31);
      if (rt_col == wd_col) begin
        exp_q.push_back('{rt_col, 0, 0, 1});
        pend_at = cycle + MAX_CYCLES + 1 + 50;
        prev_miss = 1;
      end else begin
        exp_q.push_back('{rt_col, pend_rx, pend_ry, 0});
        pend_at = cycle + ((fixed_delay != 0) ? fixed_delay : $urandom_range(1, 6));
        prev_miss = 0;
      end
      pend_valid = 1;
      rt_col = (rt_col + 1) % NUM_COLS;
    end
  end

  // Completion driver
  initial forever begin
    @(posedge clock);
    #1;
    if (pend_valid && cycle >= pend_at) begin
      bus.rt_done = 1'b1;
      bus.rt_result_x = 6'(pend_rx);
      bus.rt_result_y = 5'(pend_ry);
      pend_valid = 0;
      outstanding = 0;
      done_cyc = cycle;
    end else begin
      bus.rt_done = 1'b0;
    end
  end

  // Draw-stage ready driver
  initial forever begin
    @(posedge clock);
    #1;
    if (bp_col >= 0 && bus.col_valid && int'(bus.col_index) == bp_col && bp_cnt < 10) begin
      bus.col_ready = 1'b0;
      bp_cnt++;
    end else if (rand_ready) begin
      bus.col_ready = ($urandom_range(0, 3) != 0);
    end else begin
      bus.col_ready = 1'b1;
    end
  end

  // Output monitor / scoreboard
  initial forever begin
    @(negedge clock);
    if (!resetn) begin
      prev_valid = 0;
      prev_fd = 0;
      stalled = 0;
    end else begin
      if (stalled) begin
        chk("stall_valid", bus.col_valid, 1);
        chk("stall_index", bus.col_index, sv_idx);
        chk("stall_hit_x", bus.col_hit_x, sv_hx);
        chk("stall_hit_y", bus.col_hit_y, sv_hy);
        chk("stall_miss", bus.col_miss, sv_miss);
      end
      if (bus.col_valid && !prev_valid && exp_q.size() > 0) begin
        if (exp_q[0].miss != 0) chk("miss_latency", cycle, start_cyc + MAX_CYCLES + 1);
        else chk("done_to_valid", cycle, done_cyc + 1);
      end
      if (bus.col_valid && bus.col_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("col_index", bus.col_index, mon_e.idx);
          chk("col_hit_x", bus.col_hit_x, mon_e.hx);
          chk("col_hit_y", bus.col_hit_y, mon_e.hy);
          chk("col_miss", bus.col_miss, mon_e.miss);
        end
        beats++;
        accept_cyc = cycle;
        stalled = 0;
      end else if (bus.col_valid) begin
        stalled = 1;
        sv_idx = bus.col_index;
        sv_hx = bus.col_hit_x;
        sv_hy = bus.col_hit_y;
        sv_miss = bus.col_miss;
      end else begin
        stalled = 0;
      end
      prev_valid = bus.col_valid;
      if (frame_done) begin
        chk("frame_done_pulse", prev_fd, 0);
        chk("beats_per_frame", beats, NUM_COLS);
        chk("queue_empty_at_end", exp_q.size(), 0);
        beats = 0;
        frame_cnt++;
        last_fd_cyc = cycle;
      end
      prev_fd = frame_done;
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_rt_start"}, bus.rt_start, 0);
    chk({tag, "_col_valid"}, bus.col_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_rt_x"}, bus.rt_x, 0);
    chk({tag, "_rt_y"}, bus.rt_y, 0);
    chk({tag, "_rt_angle"}, bus.rt_angle, 0);
    chk({tag, "_col_index"}, bus.col_index, 0);
    chk({tag, "_col_miss"}, bus.col_miss, 0);
  endtask

  task automatic set_pose(input int a);
    player_x = 14'($urandom_range(0, 16383));
    player_y = 13'($urandom_range(0, 8191));
    player_angle = 8'(a);
    m_x = player_x;
    m_y = player_y;
    m_a = a;
  endtask

  task automatic issue_frame(input int a);
    @(posedge clock);
    #1;
    set_pose(a);
    fs_check = 1;
    fs_cyc = cycle;
    frame_start = 1'b1;
    @(posedge clock);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frame_cnt < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("frame_timeout", int'(frame_cnt >= target), 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    bus.rt_done = 1'b0;
    bus.rt_result_x = '0;
    bus.rt_result_y = '0;
    bus.col_ready = 1'b1;
    #1 resetn = 1'b0;
    #11;
    check_all_zero("reset");
    @(negedge clock);
    #2 resetn = 1'b1;

    // Angle sweep from heading 0, fixed 3-cycle raytracer, ready always high
    fixed_delay = 3;
    issue_frame(0);
    wait_frames(1, 5000);
    wait_idle(100);

    // Backpressure on col 5, watchdog on col 2, ignored frame_start pulses
    fixed_delay = 0;
    rand_ready = 1;
    bp_col = 5;
    bp_cnt = 0;
    wd_col = 2;
    issue_frame($urandom_range(0, 255));
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(20, 200)) @(posedge clock);
      #1;
      if (busy) begin
        player_x = 14'($urandom_range(0, 16383));
        player_y = 13'($urandom_range(0, 8191));
        player_angle = 8'($urandom_range(0, 255));
        frame_start = 1'b1;
        @(posedge clock);
        #1 frame_start = 1'b0;
      end
    end
    wait_frames(2, 30000);
    bp_col = -1;
    wd_col = -1;
    wait_idle(2000);

    // Async reset in the middle of a WAIT_RT
    issue_frame($urandom_range(0, 255));
    begin
      int n = 0;
      while (!(rt_col == 8 && outstanding) && n < 5000) begin
        @(negedge clock);
        n++;
      end
      chk("reach_col7_timeout", int'(rt_col == 8 && outstanding), 1);
    end
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    pend_valid = 0;
    outstanding = 0;
    bus.rt_done = 1'b0;
    rt_col = 0;
    beats = 0;
    fs_check = 0;
    prev_miss = 0;
    repeat (3) @(negedge clock);
    #2 resetn = 1'b1;
    issue_frame($urandom_range(0, 255));
    wait_frames(3, 10000);
    wait_idle(100);

    // frame_start held high: second sweep starts right after IDLE is re-entered
    @(posedge clock);
    #1;
    set_pose($urandom_range(0, 255));
    fs_check = 1;
    fs_cyc = cycle;
    b2b_check = 1;
    frame_start = 1'b1;
    wait_frames(4, 10000);
    begin
      int n = 0;
      while (rt_col == 0 && n < 100) begin
        @(negedge clock);
        n++;
      end
      chk("b2b_restart_timeout", int'(rt_col != 0), 1);
    end
    @(posedge clock);
    #1 frame_start = 1'b0;
    wait_frames(5, 10000);
    wait_idle(100);
    repeat (20) @(negedge clock);
    chk("no_extra_frame", busy, 0);
    chk("b2b_checked", b2b_check, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
